// File: rtl/lane_accumulator.sv
// Unpacks packed multiplier products into signed lanes, accumulates them per dot-product,
// and queues each finished result in a 2-entry valid/ready FIFO without ever stalling upstream.
module lane_accumulator #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [31:0]          in_p,
    input  logic [1:0]           in_mode,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*ACC_W-1:0]   out_acc,
    output logic [1:0]           out_mode,
    output logic [CNT_W-1:0]     out_cnt,
    output logic                 out_sat,
    output logic                 err_ovf,
    output logic                 err_mode
);

    typedef enum logic {IDLE, ACC} state_t;

    state_t             state;
    logic [1:0]         mode_q;
    logic [ACC_W-1:0]   acc_q [8];
    logic [CNT_W-1:0]   cnt_q;
    logic               sat_q;

    logic [1:0]         ext_mode;
    logic [ACC_W-1:0]   lane [8];
    logic [ACC_W:0]     sum [8];
    logic [ACC_W-1:0]   acc_nxt [8];
    logic [7:0]         lane_sat;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               sat_nxt;
    logic [8*ACC_W-1:0] push_acc;
    logic               push;

    logic [8*ACC_W-1:0] mem_acc [2];
    logic [1:0]         mem_mode [2];
    logic [CNT_W-1:0]   mem_cnt [2];
    logic               mem_sat [2];
    logic               rd_ptr;
    logic               wr_ptr;
    logic [1:0]         count;
    logic               pop;
    logic               full;
    logic               do_push;

    // Mid-accumulation beats are always unpacked with the mode captured on the first beat.
    always_comb begin
        ext_mode = (state == ACC) ? mode_q : in_mode;
        for (int k = 0; k < 8; k++) begin
            lane[k] = '0;
        end
        case (ext_mode)
            2'd0: begin
                for (int k = 0; k < 2; k++) begin
                    lane[k] = {{(ACC_W-16){in_p[16*k+15]}}, in_p[16*k +: 16]};
                end
            end
            2'd1: begin
                for (int k = 0; k < 4; k++) begin
                    lane[k] = {{(ACC_W-8){in_p[8*k+7]}}, in_p[8*k +: 8]};
                end
            end
            default: begin
                for (int k = 0; k < 8; k++) begin
                    lane[k] = {{(ACC_W-4){in_p[4*k+3]}}, in_p[4*k +: 4]};
                end
            end
        endcase
    end

    always_comb begin
        lane_sat = '0;
        push_acc = '0;
        for (int k = 0; k < 8; k++) begin
            sum[k]     = {acc_q[k][ACC_W-1], acc_q[k]} + {lane[k][ACC_W-1], lane[k]};
            acc_nxt[k] = sum[k][ACC_W-1:0];
            if (state == IDLE) begin
                acc_nxt[k] = lane[k];
            end else if (sum[k][ACC_W] != sum[k][ACC_W-1]) begin
                lane_sat[k] = 1'b1;
                acc_nxt[k]  = sum[k][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                            : {1'b0, {(ACC_W-1){1'b1}}};
            end
            push_acc[k*ACC_W +: ACC_W] = acc_nxt[k];
        end
        if (state == IDLE) begin
            cnt_nxt = CNT_W'(1);
        end else begin
            cnt_nxt = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        end
        sat_nxt = ((state == ACC) && sat_q) || (|lane_sat);
        push    = in_valid && in_last;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            mode_q   <= '0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            err_mode <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                acc_q[k] <= '0;
            end
        end else if (clear) begin
            state    <= IDLE;
            mode_q   <= '0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            err_mode <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                acc_q[k] <= '0;
            end
        end else if (in_valid) begin
            for (int k = 0; k < 8; k++) begin
                acc_q[k] <= acc_nxt[k];
            end
            cnt_q <= cnt_nxt;
            sat_q <= sat_nxt;
            if (state == IDLE) begin
                mode_q <= in_mode;
            end else if (in_mode != mode_q) begin
                err_mode <= 1'b1;
            end
            state <= in_last ? IDLE : ACC;
        end
    end

    // A push into a full FIFO only succeeds when the head leaves in the same cycle.
    assign out_valid = (count != 2'd0);
    assign full      = (count == 2'd2);
    assign pop       = out_valid && out_ready;
    assign do_push   = push && (!full || pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count   <= '0;
            err_ovf <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_acc[i]  <= '0;
                mem_mode[i] <= '0;
                mem_cnt[i]  <= '0;
                mem_sat[i]  <= 1'b0;
            end
        end else if (clear) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count   <= '0;
            err_ovf <= 1'b0;
        end else begin
            if (do_push) begin
                mem_acc[wr_ptr]  <= push_acc;
                mem_mode[wr_ptr] <= ext_mode;
                mem_cnt[wr_ptr]  <= cnt_nxt;
                mem_sat[wr_ptr]  <= sat_nxt;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && full && !pop) begin
                err_ovf <= 1'b1;
            end
            case ({do_push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign out_acc  = out_valid ? mem_acc[rd_ptr]  : '0;
    assign out_mode = out_valid ? mem_mode[rd_ptr] : '0;
    assign out_cnt  = out_valid ? mem_cnt[rd_ptr]  : '0;
    assign out_sat  = out_valid ? mem_sat[rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_lane_accumulator.sv
// Directed-vector bench: stimulus pushes hand-computed results into a scoreboard queue,
// and a monitor pops and compares every result the DUT hands out.
module tb_lane_accumulator;

    localparam int ACC_W = 24;
    localparam int CNT_W = 16;

    typedef struct {
        logic [8*ACC_W-1:0] acc;
        logic [1:0]         mode;
        logic [CNT_W-1:0]   cnt;
        logic               sat;
    } result_t;

    logic               clk;
    logic               reset_n;
    logic               clear;
    logic               in_valid;
    logic [31:0]        in_p;
    logic [1:0]         in_mode;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [8*ACC_W-1:0] out_acc;
    logic [1:0]         out_mode;
    logic [CNT_W-1:0]   out_cnt;
    logic               out_sat;
    logic               err_ovf;
    logic               err_mode;

    result_t expq[$];
    int      tests;
    int      failed;

    lane_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .clear(clear),
        .in_valid(in_valid),
        .in_p(in_p),
        .in_mode(in_mode),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_acc(out_acc),
        .out_mode(out_mode),
        .out_cnt(out_cnt),
        .out_sat(out_sat),
        .err_ovf(err_ovf),
        .err_mode(err_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8*ACC_W-1:0] packLanes(input int a0, input int a1, input int a2,
                                                     input int a3, input int a4, input int a5,
                                                     input int a6, input int a7);
        int v[8];
        logic [8*ACC_W-1:0] r;
        v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
        v[4] = a4; v[5] = a5; v[6] = a6; v[7] = a7;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            r[k*ACC_W +: ACC_W] = v[k][ACC_W-1:0];
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [8*ACC_W-1:0] act,
                               input logic [8*ACC_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expectResult(input logic [8*ACC_W-1:0] acc, input logic [1:0] mode,
                                input int cnt, input logic sat);
        result_t r;
        r.acc  = acc;
        r.mode = mode;
        r.cnt  = cnt[CNT_W-1:0];
        r.sat  = sat;
        expq.push_back(r);
    endtask

    // One beat; called just after a rising edge, returns just after the edge that captured it.
    task automatic applyStimulus(input logic [31:0] p, input logic [1:0] mode, input logic last);
        in_valid = 1'b1;
        in_p     = p;
        in_mode  = mode;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (expq.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        tests++;
        if (expq.size() != 0) begin
            failed++;
            $display("[TB] FAIL %s: %0d results outstanding, expected 0", name, expq.size());
            expq.delete();
        end
    endtask

    task automatic pulseClear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    // Monitor: every accepted output must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                tests++;
                failed++;
                $display("[TB] FAIL unexpected_result: got acc %0h cnt %0d, expected none",
                         out_acc, out_cnt);
            end else begin
                result_t r;
                r = expq.pop_front();
                checkOutput("out_acc", out_acc, r.acc);
                checkOutput("out_mode", {190'd0, out_mode}, {190'd0, r.mode});
                checkOutput("out_cnt", {176'd0, out_cnt}, {176'd0, r.cnt});
                checkOutput("out_sat", {191'd0, out_sat}, {191'd0, r.sat});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        tests     = 0;
        failed    = 0;
        reset_n   = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_p      = '0;
        in_mode   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", {191'd0, out_valid}, '0);
        checkOutput("reset_out_acc", out_acc, '0);
        checkOutput("reset_flags", {190'd0, err_ovf, err_mode}, '0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Mode 1, two identical beats.
        expectResult(packLanes(-256, 254, 6, -8, 0, 0, 0, 0), 2'd1, 2, 1'b0);
        applyStimulus(32'hFC03_7F80, 2'd1, 1'b0);
        applyStimulus(32'hFC03_7F80, 2'd1, 1'b1);
        waitDrain("drain_mode1");

        // Mode 2 single beat; result must already be at the head right after the edge.
        expectResult(packLanes(1, 2, -1, 7, 0, 1, -1, -8), 2'd2, 1, 1'b0);
        applyStimulus(32'h8F10_7F21, 2'd2, 1'b1);
        checkOutput("latency_valid", {191'd0, out_valid}, {191'd0, 1'b1});
        waitDrain("drain_mode2");

        // Mode 0 saturation in both directions over 300 beats.
        expectResult(packLanes(-8388608, 8388607, 0, 0, 0, 0, 0, 0), 2'd0, 300, 1'b1);
        for (int i = 0; i < 299; i++) begin
            applyStimulus(32'h7FFF_8000, 2'd0, 1'b0);
        end
        applyStimulus(32'h7FFF_8000, 2'd0, 1'b1);
        waitDrain("drain_mode0_sat");
        checkOutput("no_ovf_yet", {191'd0, err_ovf}, '0);

        // Overflow: third result dropped while the consumer stalls.
        out_ready = 1'b0;
        expectResult(packLanes(1, 0, 0, 0, 0, 0, 0, 0), 2'd2, 1, 1'b0);
        expectResult(packLanes(2, 0, 0, 0, 0, 0, 0, 0), 2'd2, 1, 1'b0);
        applyStimulus(32'h1, 2'd2, 1'b1);
        applyStimulus(32'h2, 2'd2, 1'b1);
        applyStimulus(32'h3, 2'd2, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("ovf_set", {191'd0, err_ovf}, {191'd0, 1'b1});
        checkOutput("ovf_head_cnt", {176'd0, out_cnt}, {176'd0, 16'd1});
        out_ready = 1'b1;
        waitDrain("drain_ovf");
        @(posedge clk);
        #1;
        checkOutput("ovf_fifo_empty", {191'd0, out_valid}, '0);
        pulseClear();
        checkOutput("clear_ovf", {191'd0, err_ovf}, '0);

        // Full FIFO with simultaneous push and pop: no drop.
        out_ready = 1'b0;
        expectResult(packLanes(4, 0, 0, 0, 0, 0, 0, 0), 2'd2, 1, 1'b0);
        expectResult(packLanes(5, 0, 0, 0, 0, 0, 0, 0), 2'd2, 1, 1'b0);
        expectResult(packLanes(6, 0, 0, 0, 0, 0, 0, 0), 2'd2, 1, 1'b0);
        applyStimulus(32'h4, 2'd2, 1'b1);
        applyStimulus(32'h5, 2'd2, 1'b1);
        out_ready = 1'b1;
        applyStimulus(32'h6, 2'd2, 1'b1);
        waitDrain("drain_pushpop");
        checkOutput("pushpop_no_ovf", {191'd0, err_ovf}, '0);

        // Mode change mid-accumulation: second beat still unpacked as mode 1.
        expectResult(packLanes(21, 20, 19, 18, 0, 0, 0, 0), 2'd1, 2, 1'b0);
        applyStimulus(32'h0102_0304, 2'd1, 1'b0);
        applyStimulus(32'h1111_1111, 2'd2, 1'b1);
        checkOutput("err_mode_set", {191'd0, err_mode}, {191'd0, 1'b1});
        waitDrain("drain_mode_err");
        pulseClear();
        checkOutput("clear_err_mode", {191'd0, err_mode}, '0);

        // Clear wins over a same-cycle last beat: nothing may be emitted.
        clear = 1'b1;
        applyStimulus(32'h7, 2'd2, 1'b1);
        clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("clear_priority", {191'd0, out_valid}, '0);

        // Reset mid-accumulation discards the partial sums.
        applyStimulus(32'h5, 2'd2, 1'b0);
        applyStimulus(32'h5, 2'd2, 1'b0);
        applyStimulus(32'h5, 2'd2, 1'b0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        checkOutput("rst_flags", {190'd0, err_ovf, err_mode}, '0);
        expectResult(packLanes(1, 0, 0, 0, 0, 0, 0, 0), 2'd2, 1, 1'b0);
        applyStimulus(32'h1, 2'd2, 1'b1);
        waitDrain("drain_after_reset");
        checkOutput("final_flags", {190'd0, err_ovf, err_mode}, '0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
